tone_generator: RTL and testbench



---
 rtl/tone_generator.sv | 205 ++++++++++++++++++++
 tb/tb_tone_generator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
// Module   : tone_generator
// Purpose  : Turns a 2-bit tone-select code into a 50 % duty square wave for
//            a buzzer. Each code has its own half-period divisor. A new code
//            is adopted only at the end of a full output period, which is the
//            high-to-low toggle, so the pin never shows a runt pulse.
//
// Ports    : clk_50MHz    in   system clock, rising edge
//            rst_n        in   asynchronous active-low reset
//            state[1:0]   in   tone-select code, synchronous to clk_50MHz
//            en           in   tone enable, 0 = silent
//            buzz_out     out  square-wave buzzer drive
//            active_sel   out  code currently being generated
//            switch_pulse out  one-cycle strobe when active_sel changes
//
// Options  : `define TONE_CADENCE_EN to gate the tone with a 50 % on/off
//            cadence of GATE_CNT clocks per phase (beeping).
//
// Revision : 1.0  initial release
// ============================================================================
module tone_generator #(
  parameter int CNT_W    = 17,       // must hold the largest DIVn-1
  parameter int DIV0     = 95420,    // half-period for code 2'b00
  parameter int DIV1     = 75758,    // half-period for code 2'b01
  parameter int DIV2     = 63776,    // half-period for code 2'b10
  parameter int DIV3     = 47801,    // half-period for code 2'b11
  parameter int GATE_CNT = 12500000  // cadence half-period (optional feature)
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic       en,
  output logic       buzz_out,
  output logic [1:0] active_sel,
  output logic       switch_pulse
);

  // --------------------------------------------------------------------------
  // Divisor constants. A half-period shorter than 2 clocks cannot be counted
  // meaningfully, so small divisors are raised to 2.
  // --------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] clamp_div(input int d);
    if (d < 2) begin
      clamp_div = CNT_W'(2);
    end else begin
      clamp_div = CNT_W'(d);
    end
  endfunction

  // Terminal counts (div-1) per code.
  localparam logic [CNT_W-1:0] c_last0 = clamp_div(DIV0) - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_last1 = clamp_div(DIV1) - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_last2 = clamp_div(DIV2) - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_last3 = clamp_div(DIV3) - CNT_W'(1);

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, deassertion is delayed by two
  // clock edges so that every flop leaves reset on the same clean edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // Tone datapath state
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             buzz_q;
  logic             buzz_d;
  logic [1:0]       active_sel_q;
  logic [1:0]       active_sel_d;
  logic [1:0]       pending_q;
  logic [1:0]       pending_d;
  logic             switch_pulse_q;
  logic             switch_pulse_d;

  logic [CNT_W-1:0] last_cnt;    // div-1 for the code being generated
  logic             toggle_evt;  // half-period boundary this cycle

  always_comb begin
    last_cnt = c_last0;
    case (active_sel_q)
      2'b00:   last_cnt = c_last0;
      2'b01:   last_cnt = c_last1;
      2'b10:   last_cnt = c_last2;
      default: last_cnt = c_last3;
    endcase
  end

  // ">=" rather than "==" lets the counter recover on its own should it ever
  // hold a value beyond the current terminal count.
  assign toggle_evt = en && (cnt_q >= last_cnt);

  always_comb begin
    cnt_d          = cnt_q;
    buzz_d         = buzz_q;
    active_sel_d   = active_sel_q;
    pending_d      = state;
    switch_pulse_d = 1'b0;

    if (!en) begin
      // Silent: abandon any partial period and follow the selector directly.
      cnt_d          = '0;
      buzz_d         = 1'b0;
      active_sel_d   = state;
      switch_pulse_d = (state != active_sel_q);
    end else if (toggle_evt) begin
      cnt_d  = '0;
      buzz_d = ~buzz_q;
      // Only the high-to-low toggle closes a full period; that is the one
      // place a new code may take over. The code sampled at that moment
      // wins, so any intermediate selections are simply discarded.
      if (buzz_q && (pending_q != active_sel_q)) begin
        active_sel_d   = pending_q;
        switch_pulse_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_q          <= '0;
      buzz_q         <= 1'b0;
      active_sel_q   <= 2'b00;
      pending_q      <= 2'b00;
      switch_pulse_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      buzz_q         <= buzz_d;
      active_sel_q   <= active_sel_d;
      pending_q      <= pending_d;
      switch_pulse_q <= switch_pulse_d;
    end
  end

  assign active_sel   = active_sel_q;
  assign switch_pulse = switch_pulse_q;

`ifdef TONE_CADENCE_EN
  // --------------------------------------------------------------------------
  // Cadence gate. gate_off_q == 0 means the "on" phase; holding the counter
  // and phase cleared while en is low makes every beep train start "on".
  // The tone counter is not affected, so pitch phase stays continuous and
  // tone switching still follows the ungated waveform.
  // --------------------------------------------------------------------------
  localparam int c_gate_w = (GATE_CNT > 1) ? $clog2(GATE_CNT) : 1;
  localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CNT - 1);

  logic [c_gate_w-1:0] gate_cnt_q;
  logic [c_gate_w-1:0] gate_cnt_d;
  logic                gate_off_q;
  logic                gate_off_d;

  always_comb begin
    gate_cnt_d = gate_cnt_q;
    gate_off_d = gate_off_q;
    if (!en) begin
      gate_cnt_d = '0;
      gate_off_d = 1'b0;
    end else if (gate_cnt_q >= c_gate_last) begin
      gate_cnt_d = '0;
      gate_off_d = ~gate_off_q;
    end else begin
      gate_cnt_d = gate_cnt_q + c_gate_w'(1);
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      gate_cnt_q <= '0;
      gate_off_q <= 1'b0;
    end else begin
      gate_cnt_q <= gate_cnt_d;
      gate_off_q <= gate_off_d;
    end
  end

  assign buzz_out = buzz_q & ~gate_off_q;
`else
  // No cadence: the pin carries the continuous tone.
  logic unused_gate_cnt;
  assign unused_gate_cnt = (GATE_CNT != 0);
  assign buzz_out        = buzz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tone_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_generator
// Purpose  : Self-checking bench for tone_generator. Directed stimulus pushes
//            the hand-computed output events (buzzer edges and switch strobes,
//            each tagged with the clock edge it must follow) into a queue; an
//            independent monitor pops and compares whenever the DUT shows an
//            output event.
// Revision : 1.0  initial release
// ============================================================================
module tb_tone_generator;

  localparam int P_DIV0 = 4;
  localparam int P_DIV1 = 6;
  localparam int P_DIV2 = 8;
  localparam int P_DIV3 = 10;
  localparam int P_GATE = 20;

  logic       clk_50MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       en        = 1'b0;
  logic [1:0] state     = 2'b00;
  logic       buzz_out;
  logic [1:0] active_sel;
  logic       switch_pulse;

  tone_generator #(
    .CNT_W   (17),
    .DIV0    (P_DIV0),
    .DIV1    (P_DIV1),
    .DIV2    (P_DIV2),
    .DIV3    (P_DIV3),
    .GATE_CNT(P_GATE)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .rst_n       (rst_n),
    .state       (state),
    .en          (en),
    .buzz_out    (buzz_out),
    .active_sel  (active_sel),
    .switch_pulse(switch_pulse)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk_50MHz) cyc <= cyc + 1;

  typedef struct {
    bit         kind;  // 0 = buzzer edge, 1 = switch strobe
    logic [1:0] val;   // new buzzer level, or new active_sel
    int         at;    // edge number after which the event must be visible
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  logic prev_buzz = 1'b0;
  bit   mon_en    = 1'b0;

  task automatic push_ev(input bit kind, input logic [1:0] val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic exp_edge(input logic v, input int at);
    push_ev(1'b0, {1'b0, v}, at);
  endtask

  task automatic exp_sw(input logic [1:0] sel, input int at);
    push_ev(1'b1, sel, at);
  endtask

  task automatic check_ev(input bit kind, input logic [1:0] val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got val=%0d at edge %0d, required no event",
               kind ? "switch" : "edge", val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val || e.at != cyc) begin
        n_bad++;
        $display("FAIL event: got %s val=%0d edge=%0d, required %s val=%0d edge=%0d",
                 kind ? "switch" : "edge", val, cyc,
                 e.kind ? "switch" : "edge", e.val, e.at);
      end
    end
  endtask

  // Monitor: sample half a clock after the active edge.
  always @(negedge clk_50MHz) begin
    if (mon_en) begin
      if (buzz_out !== prev_buzz) check_ev(1'b0, {1'b0, buzz_out});
      if (switch_pulse !== 1'b0) check_ev(1'b1, active_sel);
    end
    prev_buzz = buzz_out;
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int  t;
    int  u;
    int  v;
    ev_t e;

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_buzz",  {1'b0, buzz_out},     2'd0);
    chk("rst_sel",   active_sel,           2'd0);
    chk("rst_pulse", {1'b0, switch_pulse}, 2'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    mon_en = 1'b1;
    chk("idle_sel", active_sel, 2'd0);

    // ------- code 00, glitch-and-return, then switch to 11 -------
    t     = cyc;
    en    = 1'b1;
    state = 2'b00;
    exp_edge(1'b1, t + 4);
    exp_edge(1'b0, t + 8);
    exp_edge(1'b1, t + 12);   // pending is 10 here: never applied on a rise
    exp_edge(1'b0, t + 16);   // pending back at 00: no switch
    exp_edge(1'b1, t + 20);
    exp_edge(1'b0, t + 24);
    exp_sw(2'b11, t + 24);
    exp_edge(1'b1, t + 34);   // half-period 10 from here on
    exp_edge(1'b0, t + 44);
    exp_edge(1'b1, t + 54);
    exp_edge(1'b0, t + 58);   // en dropped mid high-phase
    exp_sw(2'b10, t + 61);    // idle follows the selector

    run_to(t + 9);  state = 2'b01;
    run_to(t + 10); state = 2'b10;
    run_to(t + 13); state = 2'b00;
    run_to(t + 17); chk("sel_after_glitch", active_sel, 2'd0);
    run_to(t + 21); state = 2'b11;
    run_to(t + 25); chk("sel_after_switch", active_sel, 2'd3);
    run_to(t + 57); en = 1'b0;
    run_to(t + 59); chk("buzz_after_en_drop", {1'b0, buzz_out}, 2'd0);
    run_to(t + 60); state = 2'b10;
    run_to(t + 62); chk("idle_sel_follow", active_sel, 2'd2);

    // ------- re-enable at code 10, switch to 11, async reset -------
    run_to(t + 65);
    u  = cyc;
    en = 1'b1;
    exp_edge(1'b1, u + 8);
    exp_edge(1'b0, u + 16);
    exp_edge(1'b1, u + 24);
    exp_edge(1'b0, u + 32);
    exp_sw(2'b11, u + 32);
    exp_edge(1'b1, u + 42);
    exp_edge(1'b0, u + 52);
    exp_edge(1'b1, u + 62);
    exp_edge(1'b0, u + 65);   // reset asserted between edges

    run_to(u + 17); state = 2'b11;
    run_to(u + 65);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_buzz",  {1'b0, buzz_out},     2'd0);
    chk("async_rst_pulse", {1'b0, switch_pulse}, 2'd0);
    chk("async_rst_sel",   active_sel,           2'd0);
    en    = 1'b0;
    state = 2'b00;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_sel",  active_sel,       2'd0);
    chk("post_rst_buzz", {1'b0, buzz_out}, 2'd0);

    // ------- code 00 continuous tone or cadence-gated beeping -------
    v  = cyc;
    en = 1'b1;
`ifdef TONE_CADENCE_EN
    exp_edge(1'b1, v + 4);
    exp_edge(1'b0, v + 8);
    exp_edge(1'b1, v + 12);
    exp_edge(1'b0, v + 16);   // rise at v+20 coincides with gate going off
    exp_edge(1'b1, v + 44);   // gate back on at v+40 while tone is low
    exp_edge(1'b0, v + 48);
    exp_edge(1'b1, v + 52);
    exp_edge(1'b0, v + 56);   // rise at v+60 is gated off again
`else
    for (int k = 1; k <= 16; k++) begin
      exp_edge(k[0], v + 4 * k);
    end
`endif
    run_to(v + 66);
    mon_en = 1'b0;

    // Anything still queued never showed up.
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_%s: got nothing, required val=%0d at edge %0d",
               e.kind ? "switch" : "edge", e.val, e.at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
